// File: rtl/pref_issue_queue.sv
// Prefetch candidate issue queue: takes up to three candidates per cycle, line-aligns and
// de-duplicates them against the FIFO and a recently-issued filter, then issues one per cycle.
module pref_issue_queue #(
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 64,
  parameter int LINE_BITS = 6,
  parameter int FILT_N    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       pref_addr1_i,
  input  logic [ADDR_W-1:0]       pref_addr2_i,
  input  logic [ADDR_W-1:0]       pref_addr3_i,
  input  logic                    pref_valid1_i,
  input  logic                    pref_valid2_i,
  input  logic                    pref_valid3_i,
  input  logic                    flush_i,
  output logic [ADDR_W-1:0]       req_addr_o,
  output logic                    req_valid_o,
  input  logic                    req_ready_i,
  output logic [15:0]             drop_cnt_o,
  output logic [$clog2(DEPTH):0]  occupancy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int FP_W  = (FILT_N > 1) ? $clog2(FILT_N) : 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-LINE_BITS){1'b1}}, {LINE_BITS{1'b0}}};

  logic [ADDR_W-1:0] fifo_mem_q [DEPTH];
  logic [ADDR_W-1:0] fifo_mem_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [ADDR_W-1:0] filt_line_q [FILT_N];
  logic [ADDR_W-1:0] filt_line_d [FILT_N];
  logic [FILT_N-1:0] filt_vld_q, filt_vld_d;
  logic [FP_W-1:0]   filt_ptr_q, filt_ptr_d;
  logic [15:0]       drop_q, drop_d;

  logic [ADDR_W-1:0] cand_line [3];
  logic [2:0]        cand_vld;
  logic [2:0]        surv;
  logic [DEPTH-1:0]  ent_vld;
  logic              pop;
  logic [OCC_W-1:0]  free;
  logic [OCC_W-1:0]  n_push;
  logic [1:0]        n_drop;
  logic [PTR_W-1:0]  wp;
  logic [16:0]       drop_sum;

  always_comb begin
    cand_line[0] = pref_addr1_i & LINE_MASK;
    cand_line[1] = pref_addr2_i & LINE_MASK;
    cand_line[2] = pref_addr3_i & LINE_MASK;
    cand_vld     = {pref_valid3_i, pref_valid2_i, pref_valid1_i};
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    logic [PTR_W-1:0] rel;
    assign rel        = PTR_W'(e) - rd_ptr_q;
    assign ent_vld[e] = ({1'b0, rel} < occ_q);
  end

  always_comb begin
    surv = '0;
    for (int i = 0; i < 3; i++) begin
      surv[i] = cand_vld[i];
      for (int j = 0; j < i; j++)
        if (cand_vld[j] && (cand_line[j] == cand_line[i])) surv[i] = 1'b0;
      for (int e = 0; e < DEPTH; e++)
        if (ent_vld[e] && (fifo_mem_q[e] == cand_line[i])) surv[i] = 1'b0;
      for (int f = 0; f < FILT_N; f++)
        if (filt_vld_q[f] && (filt_line_q[f] == cand_line[i])) surv[i] = 1'b0;
    end
  end

  // Handshake: req_valid_o/req_addr_o come from registered state only; a request is
  // consumed on a rising edge where req_valid_o & req_ready_i, and otherwise holds.
  assign req_valid_o = (occ_q != '0);
  assign req_addr_o  = req_valid_o ? fifo_mem_q[rd_ptr_q] : '0;
  assign occupancy_o = occ_q;
  assign drop_cnt_o  = drop_q;

  always_comb begin
    fifo_mem_d  = fifo_mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    occ_d       = occ_q;
    filt_line_d = filt_line_q;
    filt_vld_d  = filt_vld_q;
    filt_ptr_d  = filt_ptr_q;
    pop         = req_valid_o && req_ready_i;
    free        = OCC_W'(DEPTH) - occ_q;
    n_push      = '0;
    n_drop      = '0;
    wp          = wr_ptr_q;

    if (!flush_i) begin
      for (int i = 0; i < 3; i++) begin
        if (surv[i]) begin
          if (n_push < free) begin
            fifo_mem_d[wp] = cand_line[i];
            wp             = wp + PTR_W'(1);
            n_push         = n_push + OCC_W'(1);
          end else begin
            n_drop = n_drop + 2'd1;
          end
        end
      end
    end

    drop_sum = {1'b0, drop_q} + 17'(n_drop);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    wr_ptr_d = wp;
    occ_d    = occ_q + n_push - OCC_W'(pop);

    if (pop && !flush_i) begin
      filt_line_d[filt_ptr_q] = fifo_mem_q[rd_ptr_q];
      filt_vld_d[filt_ptr_q]  = 1'b1;
      filt_ptr_d = (filt_ptr_q == FP_W'(FILT_N-1)) ? '0 : filt_ptr_q + FP_W'(1);
    end

    if (flush_i) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      occ_d      = '0;
      filt_vld_d = '0;
      filt_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_mem_q  <= '{default: '0};
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      occ_q       <= '0;
      filt_line_q <= '{default: '0};
      filt_vld_q  <= '0;
      filt_ptr_q  <= '0;
      drop_q      <= '0;
    end else begin
      fifo_mem_q  <= fifo_mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      filt_line_q <= filt_line_d;
      filt_vld_q  <= filt_vld_d;
      filt_ptr_q  <= filt_ptr_d;
      drop_q      <= drop_d;
    end
  end

endmodule

// File: tb/tb_pref_issue_queue.sv
// Scoreboard bench for pref_issue_queue: a queue-based reference model predicts issued lines,
// occupancy and drop count; a monitor compares them each cycle.
module tb_pref_issue_queue;
  localparam int DEPTH  = 8;
  localparam int FILT_N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pref_addr1_i, pref_addr2_i, pref_addr3_i;
  logic        pref_valid1_i, pref_valid2_i, pref_valid3_i;
  logic        flush_i, req_ready_i;
  logic [63:0] req_addr_o;
  logic        req_valid_o;
  logic [15:0] drop_cnt_o;
  logic [3:0]  occupancy_o;

  logic [63:0] exp_q[$];
  logic [63:0] filt_q[$];
  int          mdl_drop;
  int          n_pass, n_total;

  pref_issue_queue #(.DEPTH(DEPTH), .ADDR_W(64), .LINE_BITS(6), .FILT_N(FILT_N)) dut (
    .clk(clk), .rst(rst),
    .pref_addr1_i(pref_addr1_i), .pref_addr2_i(pref_addr2_i), .pref_addr3_i(pref_addr3_i),
    .pref_valid1_i(pref_valid1_i), .pref_valid2_i(pref_valid2_i), .pref_valid3_i(pref_valid3_i),
    .flush_i(flush_i), .req_addr_o(req_addr_o), .req_valid_o(req_valid_o),
    .req_ready_i(req_ready_i), .drop_cnt_o(drop_cnt_o), .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
  endfunction

  function automatic logic [63:0] line_of(logic [63:0] a);
    return a & ~64'h3F;
  endfunction

  // Monitor: state observed late in the low phase, before the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      check("req_valid", {63'd0, req_valid_o}, {63'd0, exp_q.size() != 0});
      check("occupancy", {60'd0, occupancy_o}, 64'(exp_q.size()));
      check("drop_cnt", {48'd0, drop_cnt_o}, 64'(mdl_drop));
      if (exp_q.size() != 0) begin
        check("req_addr", req_addr_o, exp_q[0]);
        if (req_ready_i && rst) void'(exp_q.pop_front());
      end
      if (flush_i && rst) exp_q.delete();
    end
  end

  // One clock cycle of stimulus; the model commits its update at the rising edge.
  task automatic drive(input logic [63:0] a1, input logic v1, input logic [63:0] a2,
                       input logic v2, input logic [63:0] a3, input logic v3,
                       input logic rdy, input logic fl);
    logic [63:0] l[3];
    logic        v[3];
    logic [63:0] acc[$];
    logic [63:0] head;
    logic        pop, dup;
    int          ndrop, free;
    @(negedge clk);
    #1;
    pref_addr1_i = a1; pref_valid1_i = v1;
    pref_addr2_i = a2; pref_valid2_i = v2;
    pref_addr3_i = a3; pref_valid3_i = v3;
    req_ready_i = rdy; flush_i = fl;
    l[0] = line_of(a1); l[1] = line_of(a2); l[2] = line_of(a3);
    v[0] = v1; v[1] = v2; v[2] = v3;
    pop   = (exp_q.size() != 0) && rdy;
    head  = pop ? exp_q[0] : 64'd0;
    free  = DEPTH - exp_q.size();
    ndrop = 0;
    if (!fl) begin
      for (int i = 0; i < 3; i++) begin
        if (v[i]) begin
          dup = 1'b0;
          for (int j = 0; j < i; j++) if (v[j] && l[j] == l[i]) dup = 1'b1;
          foreach (exp_q[k]) if (exp_q[k] == l[i]) dup = 1'b1;
          foreach (filt_q[k]) if (filt_q[k] == l[i]) dup = 1'b1;
          if (!dup) begin
            if (acc.size() < free) acc.push_back(l[i]);
            else ndrop++;
          end
        end
      end
    end
    @(posedge clk);
    foreach (acc[k]) exp_q.push_back(acc[k]);
    mdl_drop = (mdl_drop + ndrop > 65535) ? 65535 : mdl_drop + ndrop;
    if (fl) filt_q.delete();
    else if (pop) begin
      filt_q.push_back(head);
      if (filt_q.size() > FILT_N) void'(filt_q.pop_front());
    end
  endtask

  task automatic idle(input logic rdy);
    drive(64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, rdy, 1'b0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_valid", {63'd0, req_valid_o}, 64'd0);
    check("rst_addr", req_addr_o, 64'd0);
    check("rst_occ", {60'd0, occupancy_o}, 64'd0);
    check("rst_drop", {48'd0, drop_cnt_o}, 64'd0);
    exp_q.delete(); filt_q.delete(); mdl_drop = 0;
    pref_valid1_i = 0; pref_valid2_i = 0; pref_valid3_i = 0;
    req_ready_i = 0; flush_i = 0;
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    n_pass = 0; n_total = 0; mdl_drop = 0;
    pref_addr1_i = 0; pref_addr2_i = 0; pref_addr3_i = 0;
    pref_valid1_i = 0; pref_valid2_i = 0; pref_valid3_i = 0;
    req_ready_i = 0; flush_i = 0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;

    // Single candidate
    drive(64'h1039, 1, 0, 0, 0, 0, 1, 0);
    #2;
    check("single_valid", {63'd0, req_valid_o}, 64'd1);
    check("single_addr", req_addr_o, 64'h1000);
    idle(1);
    #2;
    check("single_empty_valid", {63'd0, req_valid_o}, 64'd0);
    check("single_empty_occ", {60'd0, occupancy_o}, 64'd0);

    // Intra-cycle and queue duplicates
    drive(64'h2000, 1, 64'h2010, 1, 64'h2040, 1, 0, 0);
    #2;
    check("dup_occ", {60'd0, occupancy_o}, 64'd2);
    check("dup_head", req_addr_o, 64'h2000);
    drive(64'h2047, 1, 0, 0, 0, 0, 0, 0);
    #2;
    check("dup2_occ", {60'd0, occupancy_o}, 64'd2);
    check("dup2_drop", {48'd0, drop_cnt_o}, 64'd0);
    repeat (3) idle(1);

    // Filter hit, then filter wrap
    drive(64'h3000, 1, 0, 0, 0, 0, 1, 0);
    idle(1);
    drive(64'h3008, 1, 0, 0, 0, 0, 1, 0);
    #2;
    check("filt_hit_occ", {60'd0, occupancy_o}, 64'd0);
    drive(64'h4000, 1, 64'h4040, 1, 64'h4080, 1, 1, 0);
    drive(64'h40C0, 1, 0, 0, 0, 0, 1, 0);
    repeat (4) idle(1);
    drive(64'h3000, 1, 0, 0, 0, 0, 0, 0);
    #2;
    check("filt_wrap_occ", {60'd0, occupancy_o}, 64'd1);
    check("filt_wrap_addr", req_addr_o, 64'h3000);
    repeat (2) idle(1);

    // Overflow
    drive(64'h5000, 1, 64'h5040, 1, 64'h5080, 1, 0, 0);
    drive(64'h50C0, 1, 64'h5100, 1, 64'h5140, 1, 0, 0);
    drive(64'h5180, 1, 64'h51C0, 1, 64'h5200, 1, 0, 0);
    #2;
    check("ovf_occ", {60'd0, occupancy_o}, 64'd8);
    check("ovf_drop", {48'd0, drop_cnt_o}, 64'd1);
    drive(64'h5240, 1, 64'h5280, 1, 64'h52C0, 1, 1, 0);
    #2;
    check("ovf_pop_drop", {48'd0, drop_cnt_o}, 64'd4);
    check("ovf_pop_occ", {60'd0, occupancy_o}, 64'd7);

    // Backpressure stability
    for (int c = 0; c < 5; c++) begin
      drive(64'h6000 + 64'(c) * 64'hC0, 1, 64'h6040 + 64'(c) * 64'hC0, 1,
            64'h6080 + 64'(c) * 64'hC0, 1, 0, 0);
      #2;
      check("bp_addr", req_addr_o, 64'h5040);
      check("bp_valid", {63'd0, req_valid_o}, 64'd1);
    end
    repeat (9) idle(1);

    // Asynchronous reset mid-operation
    drive(64'h8000, 1, 64'h8040, 1, 64'h8080, 1, 0, 0);
    drive(64'h80C0, 1, 64'h8100, 1, 0, 0, 0, 0);
    #2;
    check("pre_rst_occ", {60'd0, occupancy_o}, 64'd5);
    async_reset();

    // Flush mid-operation, then a previously issued line is re-accepted
    drive(64'h7000, 1, 0, 0, 0, 0, 0, 0);
    drive(64'h7040, 1, 0, 0, 0, 0, 1, 0);
    drive(64'h7080, 1, 0, 0, 0, 0, 0, 0);
    drive(64'h7100, 1, 0, 0, 0, 0, 1, 1);
    #2;
    check("flush_occ", {60'd0, occupancy_o}, 64'd0);
    drive(64'h7000, 1, 0, 0, 0, 0, 0, 0);
    #2;
    check("flush_reaccept_occ", {60'd0, occupancy_o}, 64'd1);
    repeat (2) idle(1);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      drive(64'h9000 + 64'($urandom_range(0, 23)) * 64 + 64'($urandom_range(0, 63)),
            1'($urandom_range(0, 1)),
            64'h9000 + 64'($urandom_range(0, 23)) * 64 + 64'($urandom_range(0, 63)),
            1'($urandom_range(0, 1)),
            64'h9000 + 64'($urandom_range(0, 23)) * 64 + 64'($urandom_range(0, 63)),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 49) == 0));
    end
    repeat (10) idle(1);
    @(negedge clk);
    #4;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pref_issue_queue.md
# pref_issue_queue

Consumer side of the IP-stride prefetcher's three-slot candidate interface. Each cycle the block accepts up to three prefetch candidates (slots 1..3). It aligns each candidate to a cache line and drops duplicates against in-flight and recently issued lines. Surviving candidates are buffered in a FIFO, then issued one per cycle to the memory side over a valid/ready handshake.

## Interface
- DEPTH, 8: FIFO entries; power of two, at least 4.
- ADDR_W, 64: address width.
- LINE_BITS, 6: low address bits cleared for line alignment (64 B lines).
- FILT_N, 4: recently-issued-line filter entries.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset), synchronous deassert from the system.
- pref_addr1_i / pref_addr2_i / pref_addr3_i  in  ADDR_W  candidate addresses, slots 1..3.
- pref_valid1_i / pref_valid2_i / pref_valid3_i  in  1  candidate valid per slot.
- flush_i  in  1  synchronous clear of FIFO and filter.
- req_addr_o  out  ADDR_W  line-aligned prefetch address (low LINE_BITS bits = 0).
- req_valid_o  out  1  request valid.
- req_ready_i  in  1  memory side accepts.
- drop_cnt_o  out  16  saturating count of candidates dropped for lack of space.
- occupancy_o  out  $clog2(DEPTH)+1  current FIFO count.

## Operation
- Alignment: line(a) = a with bits [LINE_BITS-1:0] forced to 0. All comparisons use full-width aligned lines.
- Candidate filtering happens in slot order 1, 2, 3 within a cycle. A valid candidate is discarded silently (not counted) in any of these cases:
  - Its line equals the line of a lower-numbered valid slot in the same cycle.
  - It matches any valid FIFO entry as registered at the start of the cycle, including a head being popped that cycle.
  - It matches any valid filter entry as registered at the start of the cycle.
- Enqueue:
  - free = DEPTH − occupancy (registered value). The same-cycle pop does not add space.
  - Survivors are written in slot order into up to free entries.
  - Remaining survivors are dropped, and drop_cnt_o increases by their number, saturating at 0xFFFF.
- Issue:
  - req_valid_o = (occupancy ≠ 0).
  - req_addr_o = FIFO head.
  - A pop occurs on req_valid_o & req_ready_i.
  - The popped line is written into the filter with round-robin replacement (a pointer over FILT_N entries, wraps at FILT_N−1).
- Handshake rule: while req_valid_o = 1 and req_ready_i = 0, req_addr_o and req_valid_o hold stable.
- Pointers: read and write pointers wrap modulo DEPTH. occupancy_o ranges 0..DEPTH, so full and empty are distinguishable.
- Simultaneous push and pop: occupancy_next = occupancy + pushes − pop.
- flush_i:
  - Next cycle, the FIFO is empty and all filter entries are invalid.
  - Candidates presented in the flush cycle are discarded and not counted.
  - A handshake completing in the flush cycle counts as issued; its line is not added to the filter.
  - drop_cnt_o is not cleared.
- Reset (rst = 0), applied immediately and asynchronously, including mid-operation:
  - FIFO, filter valids, pointers and drop counter are cleared.
  - req_valid_o = 0, req_addr_o = 0, occupancy_o = 0, drop_cnt_o = 0.

## Timing
- Latency: a candidate presented at edge N into an empty FIFO appears on req_addr_o with req_valid_o = 1 after edge N, usable in cycle N+1. There is no combinational path from pref_*_i to req_*_o.
- There is no combinational path from req_ready_i to any output. req_ready_i affects state only at the next edge.
- Throughput: three enqueues and one issue per cycle maximum.
- Full FIFO with pop in the same cycle: no candidate is accepted that cycle, and all valid survivors are counted as drops.

## Test plan
- Single candidate:
  - Stimulus: slot1 = 0x1039, valid, FIFO empty; req_ready_i = 1.
  - Required: cycle N+1 shows req_valid_o = 1 and req_addr_o = 0x1000; the following cycle shows req_valid_o = 0 and occupancy_o = 0.
- Intra-cycle and queue duplicates:
  - Stimulus: slots 1/2/3 = 0x2000/0x2010/0x2040, all valid, req_ready_i = 0.
  - Required: occupancy_o = 2, with 0x2000 then 0x2040. Next cycle, slot1 = 0x2047 valid: occupancy_o stays 2 and drop_cnt_o stays 0.
- Filter:
  - Stimulus: issue 0x3000 (ready = 1); two cycles later present slot1 = 0x3008.
  - Required: no request is issued for it. After four further distinct lines have been issued (filter wraps), 0x3000 is accepted again.
- Overflow:
  - Stimulus: req_ready_i = 0; present 3 distinct lines per cycle for 3 cycles (DEPTH = 8).
  - Required: occupancy_o = 8 and drop_cnt_o = 1. A fourth cycle with 3 new lines and ready = 1 gives drop_cnt_o = 4 and occupancy_o = 7.
- Backpressure stability:
  - Stimulus: hold req_ready_i = 0 for 5 cycles while new candidates arrive.
  - Required: req_addr_o is unchanged for all 5 cycles; on ready = 1, entries drain in FIFO order, one per cycle.
- Reset and flush mid-operation:
  - Stimulus: with occupancy_o = 5, assert rst low between clock edges.
  - Required: outputs go to 0 immediately. Repeat with flush_i: next cycle occupancy_o = 0, and a previously issued line is re-accepted.
